// File: rtl/ff256_pkg.sv
// Shared GF(2^8) definitions: field polynomial, element type, dot-engine states
// and the reference shift-and-add multiply used by the multiplier block.
package ff256_pkg;

  localparam logic [8:0] FF256_POLY = 9'h11B;

  typedef logic [7:0] gf8_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } dot_state_t;

  // Low byte of the polynomial; folded back in whenever x^8 would appear.
  localparam gf8_t FF256_RED = FF256_POLY[7:0];

  // Carry-less multiply of a and b reduced modulo x^8+x^4+x^3+x+1.
  function automatic gf8_t gf8_mul(input gf8_t a, input gf8_t b);
    gf8_t acc;
    gf8_t sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ sh;
      end else begin
        acc = acc;
      end
      if (sh[7]) begin
        sh = (sh << 1) ^ FF256_RED;
      end else begin
        sh = sh << 1;
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/ff256_mult_multiplier.sv
// Combinational GF(2^8) multiplier: y = a * b over the 0x11B field.
module ff256_mult_multiplier
  import ff256_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  assign y = gf8_mul(gf8_t'(a), gf8_t'(b));

endmodule

// File: rtl/ff256_mult_dot.sv
// Streaming GF(2^8) dot-product engine: XOR-accumulates f*p over a frame of
// beats and presents the sum, term count and overflow flag on a registered
// valid/ready output. s_ready depends combinationally on m_ready by design.
module ff256_mult_dot
  import ff256_pkg::*;
#(
  parameter int MAX_TERMS = 255,
  parameter int CW        = $clog2(MAX_TERMS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [7:0]    s_f,
  input  logic [7:0]    s_p,
  input  logic          s_last,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [7:0]    m_sum,
  output logic [CW-1:0] m_count,
  output logic          m_overflow
);

  dot_state_t    state_r;
  gf8_t          acc_r;
  logic [CW-1:0] cnt_r;
  logic          m_valid_r;
  gf8_t          m_sum_r;
  logic [CW-1:0] m_count_r;
  logic          m_overflow_r;

  gf8_t          prod_s;
  logic [CW-1:0] cnt_inc_s;
  logic          xfer_s;
  logic          close_s;
  logic          drain_s;

  ff256_mult_multiplier u_mul (
    .a (s_f),
    .b (s_p),
    .y (prod_s)
  );

  // A pending result that is not being taken this cycle stalls the input.
  assign s_ready   = !rst && !(m_valid_r && !m_ready);
  assign xfer_s    = s_valid && s_ready;
  assign cnt_inc_s = cnt_r + CW'(1);
  assign close_s   = xfer_s && (s_last || (cnt_inc_s == CW'(MAX_TERMS)));
  assign drain_s   = m_valid_r && m_ready;

  assign m_valid    = m_valid_r;
  assign m_sum      = m_sum_r;
  assign m_count    = m_count_r;
  assign m_overflow = m_overflow_r;

  // Frame FSM: accumulate beats, load the result on the closing beat, hold it until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      acc_r        <= 8'h00;
      cnt_r        <= '0;
      m_valid_r    <= 1'b0;
      m_sum_r      <= 8'h00;
      m_count_r    <= '0;
      m_overflow_r <= 1'b0;
    end else if (close_s) begin
      // Closing beat: from IDLE/ACCUM, or from HOLD when the old result drains now.
      state_r      <= HOLD;
      m_valid_r    <= 1'b1;
      m_sum_r      <= acc_r ^ prod_s;
      m_count_r    <= cnt_inc_s;
      m_overflow_r <= !s_last;
      acc_r        <= 8'h00;
      cnt_r        <= '0;
    end else begin
      case (state_r)
        IDLE, ACCUM: begin
          if (xfer_s) begin
            acc_r   <= acc_r ^ prod_s;
            cnt_r   <= cnt_inc_s;
            state_r <= ACCUM;
          end else begin
            state_r <= state_r;
          end
        end
        HOLD: begin
          if (drain_s) begin
            m_valid_r <= 1'b0;
            if (xfer_s) begin
              acc_r   <= acc_r ^ prod_s;
              cnt_r   <= cnt_inc_s;
              state_r <= ACCUM;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r   <= IDLE;
          acc_r     <= 8'h00;
          cnt_r     <= '0;
          m_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ff256_mult_dot.sv
// Directed self-checking bench for ff256_mult_dot. A second instance with
// MAX_TERMS=4 exercises the forced frame close.
module tb_ff256_mult_dot;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_f = 8'h00;
  logic [7:0] s_p = 8'h00;
  logic       s_last = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_sum;
  logic [7:0] m_count;
  logic       m_overflow;

  logic       s4_valid = 1'b0;
  logic       s4_ready;
  logic [7:0] s4_f = 8'h00;
  logic [7:0] s4_p = 8'h00;
  logic       s4_last = 1'b0;
  logic       m4_valid;
  logic       m4_ready = 1'b1;
  logic [7:0] m4_sum;
  logic [2:0] m4_count;
  logic       m4_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ff256_mult_dot dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_f(s_f), .s_p(s_p), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_sum(m_sum), .m_count(m_count),
    .m_overflow(m_overflow)
  );

  ff256_mult_dot #(.MAX_TERMS(4)) dut4 (
    .clk(clk), .rst(rst),
    .s_valid(s4_valid), .s_ready(s4_ready), .s_f(s4_f), .s_p(s4_p), .s_last(s4_last),
    .m_valid(m4_valid), .m_ready(m4_ready), .m_sum(m4_sum), .m_count(m4_count),
    .m_overflow(m4_overflow)
  );

  // Drive one beat on the main instance across one rising edge.
  task automatic beat(input logic [7:0] f, input logic [7:0] p, input logic last);
    s_valid = 1'b1; s_f = f; s_p = p; s_last = last;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic idle_cycle();
    s_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0b exp 0", m_valid); end
    checks++; if (m_sum !== 8'h00) begin errors++; $display("FAIL reset_m_sum got %h exp 00", m_sum); end
    checks++; if (m_count !== 8'd0) begin errors++; $display("FAIL reset_m_count got %0d exp 0", m_count); end
    checks++; if (m_overflow !== 1'b0) begin errors++; $display("FAIL reset_m_overflow got %0b exp 0", m_overflow); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %0b exp 0", s_ready); end
    rst = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL post_reset_s_ready got %0b exp 1", s_ready); end
  endtask

  task automatic test_single();
    m_ready = 1'b1;
    beat(8'h57, 8'h83, 1'b1);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b exp 1", m_valid); end
    checks++; if (m_sum !== 8'hC1) begin errors++; $display("FAIL single_sum got %h exp c1", m_sum); end
    checks++; if (m_count !== 8'd1) begin errors++; $display("FAIL single_count got %0d exp 1", m_count); end
    checks++; if (m_overflow !== 1'b0) begin errors++; $display("FAIL single_ovf got %0b exp 0", m_overflow); end
    idle_cycle();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %0b exp 0", m_valid); end
  endtask

  task automatic test_multi();
    m_ready = 1'b1;
    beat(8'h57, 8'h83, 1'b0);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL two_midframe_valid got %0b exp 0", m_valid); end
    beat(8'h53, 8'hCA, 1'b1);
    checks++; if (m_sum !== 8'hC0) begin errors++; $display("FAIL two_sum got %h exp c0", m_sum); end
    checks++; if (m_count !== 8'd2) begin errors++; $display("FAIL two_count got %0d exp 2", m_count); end
    idle_cycle();
    beat(8'h57, 8'h83, 1'b0);
    beat(8'h00, 8'hFF, 1'b0);
    beat(8'h53, 8'hCA, 1'b1);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL three_valid got %0b exp 1", m_valid); end
    checks++; if (m_sum !== 8'hC0) begin errors++; $display("FAIL three_sum got %h exp c0", m_sum); end
    checks++; if (m_count !== 8'd3) begin errors++; $display("FAIL three_count got %0d exp 3", m_count); end
    idle_cycle();
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    beat(8'h02, 8'h03, 1'b1);
    s_valid = 1'b1; s_f = 8'h57; s_p = 8'h83; s_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready[%0d] got %0b exp 0", i, s_ready); end
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %0b exp 1", i, m_valid); end
      checks++; if (m_sum !== 8'h06) begin errors++; $display("FAIL bp_sum[%0d] got %h exp 06", i, m_sum); end
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b exp 1", s_ready); end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid got %0b exp 1", m_valid); end
    checks++; if (m_sum !== 8'hC1) begin errors++; $display("FAIL bp_next_sum got %h exp c1", m_sum); end
    idle_cycle();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b exp 0", m_valid); end
  endtask

  task automatic test_overflow();
    m4_ready = 1'b1;
    s4_valid = 1'b1; s4_f = 8'h01; s4_p = 8'h01; s4_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) begin
        checks++; if (m4_valid !== 1'b0) begin errors++; $display("FAIL ovf_early_valid[%0d] got %0b exp 0", i, m4_valid); end
      end else begin
        checks++; if (m4_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %0b exp 1", m4_valid); end
      end
    end
    checks++; if (m4_sum !== 8'h00) begin errors++; $display("FAIL ovf_sum got %h exp 00", m4_sum); end
    checks++; if (m4_count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d exp 4", m4_count); end
    checks++; if (m4_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", m4_overflow); end
    s4_f = 8'h02; s4_p = 8'h03; s4_last = 1'b1;
    @(posedge clk); #1;
    s4_valid = 1'b0; s4_last = 1'b0;
    checks++; if (m4_valid !== 1'b1) begin errors++; $display("FAIL ovf_next_valid got %0b exp 1", m4_valid); end
    checks++; if (m4_sum !== 8'h06) begin errors++; $display("FAIL ovf_next_sum got %h exp 06", m4_sum); end
    checks++; if (m4_count !== 3'd1) begin errors++; $display("FAIL ovf_next_count got %0d exp 1", m4_count); end
    checks++; if (m4_overflow !== 1'b0) begin errors++; $display("FAIL ovf_next_flag got %0b exp 0", m4_overflow); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midframe();
    m_ready = 1'b1;
    beat(8'h57, 8'h83, 1'b0);
    beat(8'h57, 8'h83, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b exp 0", m_valid); end
    beat(8'h02, 8'h03, 1'b1);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rstmid_new_valid got %0b exp 1", m_valid); end
    checks++; if (m_sum !== 8'h06) begin errors++; $display("FAIL rstmid_sum got %h exp 06", m_sum); end
    checks++; if (m_count !== 8'd1) begin errors++; $display("FAIL rstmid_count got %0d exp 1", m_count); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b1;
    s_valid = 1'b1; s_f = 8'h53; s_p = 8'hCA; s_last = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL b2b_s_ready[%0d] got %0b exp 1", i, s_ready); end
      @(posedge clk); #1;
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %0b exp 1", i, m_valid); end
      checks++; if (m_sum !== 8'h01) begin errors++; $display("FAIL b2b_sum[%0d] got %h exp 01", i, m_sum); end
      checks++; if (m_count !== 8'd1) begin errors++; $display("FAIL b2b_count[%0d] got %0d exp 1", i, m_count); end
    end
    s_valid = 1'b0; s_last = 1'b0;
    @(posedge clk); #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b exp 0", m_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_overflow();
    test_reset_midframe();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
